// File: rtl/requant_stage.sv
// rtl/requant_stage.sv - requantize signed 32-bit beats to OUT_W-bit outputs; optional REQUANT_SAT_CNT_EN saturation counter
module requant_stage #(
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6,
    parameter int OUT_MIN = -128,
    parameter int OUT_MAX = 127
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    input  logic [31:0]        scale_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [OUT_W-1:0]   out_zp_i,
    input  logic               data_valid_i,
    input  logic [31:0]        data_i,
    output logic               data_ready_o,
    output logic               data_valid_o,
    output logic [OUT_W-1:0]   data_o,
    input  logic               data_ready_i
`ifdef REQUANT_SAT_CNT_EN
    ,
    output logic [15:0]        sat_count_o
`endif
);

    localparam logic signed [65:0]      MIN_Y = 66'(OUT_MIN);
    localparam logic signed [65:0]      MAX_Y = 66'(OUT_MAX);
    localparam logic signed [OUT_W-1:0] MIN_O = OUT_W'(OUT_MIN);
    localparam logic signed [OUT_W-1:0] MAX_O = OUT_W'(OUT_MAX);

    // stored configuration
    logic signed [31:0]      scale_q, scale_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic signed [OUT_W-1:0] zp_q, zp_d;
    logic                    loaded_q, loaded_d;

    // pipeline registers; each stage carries the config its beat was accepted with
    logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [63:0]      p1_q, p1_d;
    logic [SHIFT_W-1:0]      sh1_q, sh1_d;
    logic signed [OUT_W-1:0] zp1_q, zp1_d, zp2_q, zp2_d;
    logic signed [64:0]      r2_q, r2_d;
    logic signed [OUT_W-1:0] out3_q, out3_d;

    logic                    en1, en2, en3;
    logic signed [31:0]      scale_act;
    logic [SHIFT_W-1:0]      shift_act;
    logic signed [OUT_W-1:0] zp_act;
    logic                    loaded_act;
    logic [SHIFT_W-1:0]      sh_eff;
    logic signed [64:0]      p_ext, rnd;
    logic signed [65:0]      y;
    logic                    y_sat;

    assign data_ready_o = en1;
    assign data_valid_o = v3_q;
    assign data_o       = out3_q;

    // ready chain, active config selection and all three datapath stages
    always_comb begin
        en3 = !v3_q || data_ready_i;
        en2 = !v2_q || en3;
        en1 = !v1_q || en2;

        scale_act  = cfg_valid_i ? $signed(scale_i)  : scale_q;
        shift_act  = cfg_valid_i ? shift_i           : shift_q;
        zp_act     = cfg_valid_i ? $signed(out_zp_i) : zp_q;
        loaded_act = cfg_valid_i || loaded_q;

        scale_d  = scale_act;
        shift_d  = shift_act;
        zp_d     = zp_act;
        loaded_d = loaded_act;

        // S1: full signed product; beats arriving before any config are swallowed
        v1_d  = v1_q;
        p1_d  = p1_q;
        sh1_d = sh1_q;
        zp1_d = zp1_q;
        if (en1) begin
            v1_d  = data_valid_i && loaded_act;
            p1_d  = 64'($signed(data_i)) * 64'(scale_act);
            sh1_d = shift_act;
            zp1_d = zp_act;
        end

        // S2: round half toward +inf then arithmetic shift, in 65 bits
        sh_eff = (sh1_q > SHIFT_W'(62)) ? SHIFT_W'(62) : sh1_q;
        p_ext  = 65'(p1_q);
        rnd    = '0;
        v2_d   = v2_q;
        r2_d   = r2_q;
        zp2_d  = zp2_q;
        if (en2) begin
            v2_d  = v1_q;
            zp2_d = zp1_q;
            if (sh_eff == '0) begin
                r2_d = p_ext;
            end else begin
                rnd  = 65'sd1 <<< (sh_eff - SHIFT_W'(1));
                r2_d = (p_ext + rnd) >>> sh_eff;
            end
        end

        // S3: add zero point and clamp
        y     = 66'(r2_q) + 66'(zp2_q);
        y_sat = (y > MAX_Y) || (y < MIN_Y);
        v3_d   = v3_q;
        out3_d = out3_q;
        if (en3) begin
            v3_d = v2_q;
            if (y > MAX_Y) begin
                out3_d = MAX_O;
            end else if (y < MIN_Y) begin
                out3_d = MIN_O;
            end else begin
                out3_d = y[OUT_W-1:0];
            end
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scale_q  <= '0;
            shift_q  <= '0;
            zp_q     <= '0;
            loaded_q <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            p1_q     <= '0;
            sh1_q    <= '0;
            zp1_q    <= '0;
            zp2_q    <= '0;
            r2_q     <= '0;
            out3_q   <= '0;
        end else begin
            scale_q  <= scale_d;
            shift_q  <= shift_d;
            zp_q     <= zp_d;
            loaded_q <= loaded_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            p1_q     <= p1_d;
            sh1_q    <= sh1_d;
            zp1_q    <= zp1_d;
            zp2_q    <= zp2_d;
            r2_q     <= r2_d;
            out3_q   <= out3_d;
        end
    end

`ifdef REQUANT_SAT_CNT_EN
    logic        sat3_q, sat3_d;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    assign sat_count_o = sat_cnt_q;

    // saturation flag follows the output beat; count on handshake, clear on new config
    always_comb begin
        sat3_d = sat3_q;
        if (en3) begin
            sat3_d = v2_q && y_sat;
        end
        sat_cnt_d = sat_cnt_q;
        if (v3_q && data_ready_i && sat3_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
        if (cfg_valid_i) begin
            sat_cnt_d = '0;
        end
    end

    // saturation counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat3_q    <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat3_q    <= sat3_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = y_sat;
`endif

endmodule

// File: tb/tb_requant_stage.sv
// tb/tb_requant_stage.sv - self-checking bench for requant_stage
module tb_requant_stage;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              cfg_valid_i = 1'b0;
    logic [31:0]       scale_i = '0;
    logic [5:0]        shift_i = '0;
    logic [7:0]        out_zp_i = '0;
    logic              data_valid_i = 1'b0;
    logic [31:0]       data_i = '0;
    logic              data_ready_o;
    logic              data_valid_o;
    logic signed [7:0] data_o;
    logic              data_ready_i = 1'b1;
`ifdef REQUANT_SAT_CNT_EN
    logic [15:0]       sat_count_o;
`endif

    int errors = 0;
    int checks = 0;

    requant_stage dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_valid_i  (cfg_valid_i),
        .scale_i      (scale_i),
        .shift_i      (shift_i),
        .out_zp_i     (out_zp_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .data_valid_o (data_valid_o),
        .data_o       (data_o),
        .data_ready_i (data_ready_i)
`ifdef REQUANT_SAT_CNT_EN
        ,
        .sat_count_o  (sat_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        bit     sat;
    } exp_t;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference: plain integer arithmetic with explicit floor division
    function automatic exp_t model(input longint d, input longint s, input int shift, input longint zp);
        exp_t   e;
        longint p, r, dv, num, y;
        int     sh;
        p  = d * s;
        sh = (shift > 62) ? 62 : shift;
        if (sh == 0) begin
            r = p;
        end else begin
            dv  = longint'(1) << sh;
            num = p + dv / 2;
            r   = num / dv;
            if ((num % dv) != 0 && num < 0) r = r - 1;
        end
        y     = r + zp;
        e.sat = (y > 127) || (y < -128);
        e.val = (y > 127) ? 127 : ((y < -128) ? -128 : y);
        return e;
    endfunction

    // scoreboard state
    exp_t              q[$];
    logic              m_loaded = 1'b0;
    longint            m_scale = 0, m_zp = 0;
    int                m_shift = 0;
    int                m_sat = 0;
    bit                prev_stall = 1'b0;
    logic signed [7:0] prev_data = '0;

    // per-cycle compare: ready rule, hold stability, ordered output data, saturation count
    always @(negedge clk) begin
        exp_t   e;
        longint a_scale, a_zp;
        int     a_shift;
        bit     a_loaded;
        if (rst_i) begin
            q.delete();
            m_loaded = 1'b0; m_scale = 0; m_zp = 0; m_shift = 0; m_sat = 0;
            prev_stall = 1'b0;
        end else begin
            check("ready_rule", data_ready_o, !(q.size() == 3 && !data_ready_i));
`ifdef REQUANT_SAT_CNT_EN
            check("sat_count", sat_count_o, m_sat);
`endif
            if (prev_stall) begin
                check("hold_valid", data_valid_o, 1);
                check("hold_data", data_o, prev_data);
            end
            if (data_valid_o) begin
                if (q.size() == 0) begin
                    check("stale_beat", data_valid_o, 0);
                end else if (data_ready_i) begin
                    e = q.pop_front();
                    check("stream_data", data_o, e.val);
                    if (e.sat && m_sat < 16'hFFFF) m_sat++;
                end
            end
            a_loaded = m_loaded || cfg_valid_i;
            a_scale  = cfg_valid_i ? longint'($signed(scale_i)) : m_scale;
            a_shift  = cfg_valid_i ? int'(shift_i) : m_shift;
            a_zp     = cfg_valid_i ? longint'($signed(out_zp_i)) : m_zp;
            if (cfg_valid_i) begin
                m_loaded = 1'b1; m_scale = a_scale; m_shift = a_shift; m_zp = a_zp; m_sat = 0;
            end
            if (data_valid_i && data_ready_o && a_loaded)
                q.push_back(model(longint'($signed(data_i)), a_scale, a_shift, a_zp));
            prev_stall = data_valid_o && !data_ready_i;
            prev_data  = data_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [31:0] s, input logic [5:0] sh, input logic [7:0] zp);
        cfg_valid_i = 1'b1; scale_i = s; shift_i = sh; out_zp_i = zp;
        tick();
        cfg_valid_i = 1'b0;
    endtask

    // one beat with ready held high: valid must rise exactly on the third edge counting the accept edge
    task automatic send_single(input string name, input logic [31:0] d, input logic signed [7:0] exp);
        data_ready_i = 1'b1;
        data_valid_i = 1'b1;
        data_i = d;
        @(negedge clk);
        check({name, "_accept"}, data_ready_o, 1);
        tick();
        data_valid_i = 1'b0;
        cfg_valid_i  = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, data_valid_o, 0);
        tick();
        @(negedge clk);
        check({name, "_lat2"}, data_valid_o, 0);
        tick();
        @(negedge clk);
        check({name, "_valid"}, data_valid_o, 1);
        check({name, "_data"}, data_o, exp);
        tick();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        data_valid_i = 1'b0;
        cfg_valid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("reset_valid", data_valid_o, 0);
        check("reset_data", data_o, 0);
        check("reset_ready", data_ready_o, 1);
        tick();
    endtask

    initial begin
        int acc, cyc, stall;
        bit hold;
        exp_t e;

        // pin the reference model with hand-computed values
        e = model(100, 64'h40000000, 31, 0);   check("model_100", e.val, 50);
        e = model(101, 64'h40000000, 31, 0);   check("model_101", e.val, 51);
        e = model(-101, 64'h40000000, 31, 0);  check("model_m101", e.val, -50);
        e = model(-100, 64'h40000000, 31, 0);  check("model_m100", e.val, -50);
        e = model(1000, 64'h40000000, 31, 10); check("model_sat_hi", e.val, 127);
        e = model(-1000, 64'h40000000, 31, 10); check("model_sat_lo", e.val, -128);

        tick();
        do_reset();

        // rounding and latency
        do_cfg(32'h40000000, 6'd31, 8'd0);
        send_single("t1_100", 32'd100, 8'sd50);
        send_single("t2_101", 32'd101, 8'sd51);
        send_single("t2_m101", 32'hFFFFFF9B, -8'sd50);
        send_single("t2_m100", 32'hFFFFFF9C, -8'sd50);

        // clamp at both ends
        do_cfg(32'h40000000, 6'd31, 8'd10);
        send_single("t3_hi", 32'd1000, 8'sd127);
        send_single("t3_lo", 32'hFFFFFC18, -8'sd128);
`ifdef REQUANT_SAT_CNT_EN
        check("t3_sat_count", sat_count_o, 2);
`endif

        // beats before any config are swallowed
        do_reset();
        data_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = 32'(i * 7 + 3);
            @(negedge clk);
            check("t4_ready", data_ready_o, 1);
            check("t4_no_valid", data_valid_o, 0);
            tick();
        end
        data_valid_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t4_drained", data_valid_o, 0);
            tick();
        end
        cfg_valid_i = 1'b1; scale_i = 32'h40000000; shift_i = 6'd30; out_zp_i = 8'd5;
        send_single("t4_cfg_beat", 32'd100, 8'sd105);

        // random stream with stalls
        acc = 0; cyc = 0; stall = 0; hold = 1'b0;
        while (acc < 64 && cyc < 3000) begin
            if (stall > 0) begin
                data_ready_i = 1'b0; stall--;
            end else if ($urandom_range(0, 2) == 0) begin
                data_ready_i = 1'b0; stall = $urandom_range(0, 4);
            end else begin
                data_ready_i = 1'b1;
            end
            if (!hold) begin
                data_valid_i = ($urandom_range(0, 3) != 0);
                data_i = 32'($urandom_range(0, 4000)) - 32'd2000;
            end
            cfg_valid_i = ($urandom_range(0, 9) == 0);
            if (cfg_valid_i) begin
                scale_i  = $urandom;
                shift_i  = ($urandom_range(0, 7) == 0) ? 6'(($urandom_range(0, 1) == 0) ? 0 : 63)
                                                       : 6'($urandom_range(28, 36));
                out_zp_i = 8'($urandom);
            end
            @(negedge clk);
            if (data_valid_i && data_ready_o) acc++;
            hold = data_valid_i && !data_ready_o;
            tick();
            cyc++;
        end
        check("t5_all_accepted", acc, 64);
        data_valid_i = 1'b0; cfg_valid_i = 1'b0; data_ready_i = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t5_drained", q.size(), 0);

        // reset with a full, stalled pipe
        data_ready_i = 1'b0;
        data_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = 32'(i + 1);
            tick();
        end
        data_valid_i = 1'b0;
        @(negedge clk);
        check("t6_full", data_ready_o, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("t6_valid_cleared", data_valid_o, 0);
        check("t6_data_cleared", data_o, 0);
        tick();
        data_ready_i = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("t6_no_stale", data_valid_o, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
